sync_prefetch_fifo_wconv: RTL and testbench

//  Single-clock first-word-fall-through FIFO with integer write->read width upsizing.

---
 rtl/sync_prefetch_fifo_wconv_if.sv | 28 ++
 rtl/sync_prefetch_fifo_wconv.sv | 90 +++++++++
 tb/tb_sync_prefetch_fifo_wconv.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sync_prefetch_fifo_wconv_if.sv
// sync_prefetch_fifo_wconv_if: producer/consumer bundle for the width-upsizing prefetch FIFO
//   master (producer/consumer side) drives flush, wr_en, wr_data, rd_en
//   slave (FIFO side) returns wr_vld, rd_vld, rd_data, rd_count, almost_full, overflow, underflow
interface sync_prefetch_fifo_wconv_if #(
  parameter int WR_DATA_WIDTH  = 8,
  parameter int RATIO          = 2,
  parameter int RD_DEPTH_WIDTH = 11
);
  logic                              flush;
  logic                              wr_en;
  logic                              wr_vld;
  logic [WR_DATA_WIDTH-1:0]          wr_data;
  logic                              rd_en;
  logic                              rd_vld;
  logic [WR_DATA_WIDTH*RATIO-1:0]    rd_data;
  logic [RD_DEPTH_WIDTH+1:0]         rd_count;
  logic                              almost_full;
  logic                              overflow;
  logic                              underflow;
  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  wr_vld, rd_vld, rd_data, rd_count, almost_full, overflow, underflow
  );
  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output wr_vld, rd_vld, rd_data, rd_count, almost_full, overflow, underflow
  );
endinterface

// File: rtl/sync_prefetch_fifo_wconv.sv
// sync_prefetch_fifo_wconv: single-clock FWFT FIFO packing RATIO write beats (LSB-first) into one read word
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sync_prefetch_fifo_wconv_if (write/read handshakes, level and sticky flags)
module sync_prefetch_fifo_wconv #(
  parameter int WR_DATA_WIDTH  = 8,
  parameter int RATIO          = 2,
  parameter int RD_DEPTH_WIDTH = 11,
  parameter int AF_THRESH      = 2040
) (
  input logic                       clk,
  input logic                       rst_n,
  sync_prefetch_fifo_wconv_if.slave bus
);
  localparam int RW    = WR_DATA_WIDTH * RATIO;
  localparam int AW    = RD_DEPTH_WIDTH;
  localparam int PW    = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int DEPTH = 1 << AW;
  logic [RW-1:0]                        r_mem [DEPTH];
  logic [AW:0]                          r_wptr, r_rptr, w_ram_cnt;
  logic [PW-1:0]                        r_pack_cnt;
  logic [RATIO-1:0][WR_DATA_WIDTH-1:0]  r_pack;
  logic [RW-1:0]                        r_ram_q, r_out, w_word;
  logic r_pend, r_out_vld, r_af, r_ovf, r_unf;
  logic w_full, w_empty, w_last, w_wr_vld, w_beat, w_push, w_pop, w_move, w_issue;
  assign w_ram_cnt = r_wptr - r_rptr;
  assign w_empty   = r_wptr == r_rptr;
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_last    = r_pack_cnt == PW'(RATIO - 1);
  // Only the word-completing beat is held back when the RAM is full; no path from rd_en.
  assign w_wr_vld  = rst_n && !(w_full && w_last);
  assign w_beat    = bus.wr_en && w_wr_vld && !bus.flush;
  assign w_push    = w_beat && w_last;
  assign w_pop     = bus.rd_en && r_out_vld && !bus.flush;
  // r_pend marks a word sitting in the RAM read register; it moves to the output when that frees up.
  assign w_move    = r_pend && (!r_out_vld || w_pop);
  assign w_issue   = !w_empty && (!r_pend || w_move) && !bus.flush;
  // The incoming beat fills the top slot directly, so the word is written to RAM on the same edge.
  always_comb begin
    w_word = r_pack;
    w_word[RW-1 -: WR_DATA_WIDTH] = bus.wr_data;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_word;
    if (w_issue) r_ram_q <= r_mem[r_rptr[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_pack_cnt <= '0;
      r_pack     <= '0;
      r_pend     <= 1'b0;
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_af       <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else if (bus.flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_pack_cnt <= '0;
      r_pend     <= 1'b0;
      r_out_vld  <= 1'b0;
      r_af       <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      if (w_beat) begin
        r_pack[r_pack_cnt] <= bus.wr_data;
        r_pack_cnt         <= w_last ? '0 : r_pack_cnt + 1'b1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_issue) r_rptr <= r_rptr + 1'b1;
      if (w_move) r_out <= r_ram_q;
      r_pend    <= w_issue || (r_pend && !w_move);
      r_out_vld <= w_move || (r_out_vld && !w_pop);
      r_af      <= w_ram_cnt >= (AW + 1)'(AF_THRESH);
      r_ovf     <= r_ovf || (bus.wr_en && !w_wr_vld);
      r_unf     <= r_unf || (bus.rd_en && !r_out_vld);
    end
  end
  assign bus.wr_vld      = w_wr_vld;
  assign bus.rd_vld      = r_out_vld;
  assign bus.rd_data     = r_out;
  assign bus.rd_count    = {1'b0, w_ram_cnt} + (AW + 2)'(r_pend) + (AW + 2)'(r_out_vld);
  assign bus.almost_full = r_af;
  assign bus.overflow    = r_ovf;
  assign bus.underflow   = r_unf;
endmodule

// File: tb/tb_sync_prefetch_fifo_wconv.sv
// tb_sync_prefetch_fifo_wconv: scoreboard bench for the width-upsizing prefetch FIFO
module tb_sync_prefetch_fifo_wconv;
  localparam int W = 8, R = 2, AW = 11, AF = 2040;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0, bad = 0, pops = 0, p0;
  logic [W*R-1:0] q[$];
  logic [W-1:0]   beats[$];
  logic [W*R-1:0] wd;
  bit e_ovf, e_unf;
  sync_prefetch_fifo_wconv_if #(.WR_DATA_WIDTH(W), .RATIO(R), .RD_DEPTH_WIDTH(AW)) bus ();
  sync_prefetch_fifo_wconv #(.WR_DATA_WIDTH(W), .RATIO(R), .RD_DEPTH_WIDTH(AW), .AF_THRESH(AF))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic clear_model();
    q.delete();
    beats.delete();
    e_ovf = 0;
    e_unf = 0;
  endtask
  // Monitor: level, flags and popped data against the reference queue.
  always @(negedge clk) if (rst_n) begin
    chk("rd_count", bus.rd_count, q.size());
    chk("overflow", bus.overflow, e_ovf);
    chk("underflow", bus.underflow, e_unf);
    if (bus.rd_en && bus.rd_vld && !bus.flush) begin
      pops++;
      if (q.size() == 0) chk("rd_vld_when_empty", bus.rd_vld, 0);
      else chk("rd_data", bus.rd_data, q.pop_front());
    end
  end
  // Stimulus side: accepted beats are packed LSB-first and the expected word is queued.
  always @(negedge clk) if (rst_n) begin
    #2;
    if (beats.size() != R - 1) chk("wr_vld_partial", bus.wr_vld, 1);
    if (bus.flush) clear_model();
    else begin
      if (bus.wr_en && !bus.wr_vld) e_ovf = 1;
      if (bus.rd_en && !bus.rd_vld) e_unf = 1;
      if (bus.wr_en && bus.wr_vld) begin
        beats.push_back(bus.wr_data);
        if (beats.size() == R) begin
          wd = '0;
          for (int k = 0; k < R; k++) wd = wd | ((W*R)'(beats[k]) << (k * W));
          q.push_back(wd);
          beats.delete();
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit we, input bit re, input bit fl, input logic [W-1:0] d);
    bus.wr_en = we;
    bus.rd_en = re;
    bus.flush = fl;
    bus.wr_data = d;
    step();
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, '0);
  endtask
  initial begin
    bus.flush = 0;
    bus.wr_en = 0;
    bus.rd_en = 0;
    bus.wr_data = '0;
    #1 rst_n = 0;
    #1;
    chk("rst_wr_vld", bus.wr_vld, 0);
    chk("rst_rd_vld", bus.rd_vld, 0);
    chk("rst_rd_count", bus.rd_count, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    #20 rst_n = 1;
    step();
    chk("wr_vld_after_rst", bus.wr_vld, 1);
    chk("af_after_rst", bus.almost_full, 0);
    drive(1, 0, 0, 8'h11);
    drive(1, 0, 0, 8'h22);
    bus.wr_en = 0;
    chk("lat_e0", bus.rd_vld, 0);
    step();
    chk("lat_e1", bus.rd_vld, 0);
    step();
    chk("lat_e2", bus.rd_vld, 1);
    chk("lat_data", bus.rd_data, 16'h2211);
    chk("lat_count", bus.rd_count, 1);
    drive(0, 1, 0, '0);
    idle(2);
    repeat (2041 * R) drive(1, 0, 0, W'($urandom));
    idle(3);
    chk("af_below", bus.almost_full, 0);
    chk("count_2041", bus.rd_count, 2041);
    repeat (R) drive(1, 0, 0, W'($urandom));
    idle(3);
    chk("af_at", bus.almost_full, 1);
    repeat (8 * R) drive(1, 0, 0, W'($urandom));
    idle(3);
    chk("count_full", bus.rd_count, 2050);
    chk("wr_vld_full_first_beat", bus.wr_vld, 1);
    drive(1, 0, 0, W'($urandom));
    chk("wr_vld_full_last_beat", bus.wr_vld, 0);
    chk("no_ovf_yet", bus.overflow, 0);
    drive(1, 0, 0, W'($urandom));
    chk("ovf_set", bus.overflow, 1);
    bus.wr_en = 0;
    p0 = pops;
    bus.rd_en = 1;
    repeat (100) step();
    chk("sustained_100", pops - p0, 100);
    repeat (2000) step();
    bus.rd_en = 0;
    drive(0, 0, 1, '0);
    drive(0, 1, 0, '0);
    chk("unf_set", bus.underflow, 1);
    chk("unf_count", bus.rd_count, 0);
    drive(0, 0, 1, '0);
    chk("unf_flushed", bus.underflow, 0);
    repeat (3 * R + 1) drive(1, 0, 0, W'($urandom));
    idle(3);
    drive(1, 1, 1, W'($urandom));
    chk("flush_rd_vld", bus.rd_vld, 0);
    chk("flush_count", bus.rd_count, 0);
    drive(1, 0, 0, 8'hAA);
    drive(1, 0, 0, 8'hBB);
    bus.wr_en = 0;
    step();
    step();
    chk("fresh_vld", bus.rd_vld, 1);
    chk("fresh_word", bus.rd_data, 16'hBBAA);
    drive(0, 1, 0, '0);
    idle(2);
    repeat (20 * R) drive(1, 0, 0, W'($urandom));
    idle(3);
    p0 = pops;
    bus.rd_en = 1;
    repeat (20) step();
    chk("burst_20", pops - p0, 20);
    bus.rd_en = 0;
    bus.wr_en = 1;
    bus.rd_en = 1;
    repeat (1000 * R) begin
      bus.wr_data = W'($urandom);
      step();
    end
    bus.wr_en = 0;
    repeat (10) step();
    bus.rd_en = 0;
    chk("stream_drained", bus.rd_count, 0);
    repeat (3000) drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0, W'($urandom));
    repeat (3000) drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 399) == 0, W'($urandom));
    bus.wr_en = 1;
    bus.rd_en = 1;
    bus.flush = 0;
    repeat (5) begin
      bus.wr_data = W'($urandom);
      step();
    end
    #2 rst_n = 0;
    clear_model();
    #1;
    chk("async_rst_rd_vld", bus.rd_vld, 0);
    chk("async_rst_wr_vld", bus.wr_vld, 0);
    chk("async_rst_count", bus.rd_count, 0);
    bus.wr_en = 0;
    bus.rd_en = 0;
    repeat (2) step();
    #2 rst_n = 1;
    step();
    chk("post_rst_wr_vld", bus.wr_vld, 1);
    chk("post_rst_rd_vld", bus.rd_vld, 0);
    repeat (10 * R) drive(1, 0, 0, W'($urandom));
    idle(3);
    bus.rd_en = 1;
    repeat (12) step();
    bus.rd_en = 0;
    step();
    chk("final_empty", bus.rd_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
